// File: rtl/vga_pkg.sv
// Shared VGA geometry and player sprite constants, common to the motion controller and draw stage.
package vga_pkg;

    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;

    localparam int PLAYER_W = 30;
    localparam int PLAYER_H = 80;
    localparam int Y_GROUND = 500;

    typedef enum logic [1:0] {STAND, WALK, JUMP} player_state_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing bundle passed along the draw pipeline.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/frame_tick_gen.sv
// Registered one-cycle pulse on each vblnk rising edge; the per-frame update strobe.
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic vblnk,
    output logic frame_tick
);
    logic vblnk_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_d    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vblnk_d    <= vblnk;
            frame_tick <= vblnk & ~vblnk_d;
        end
    end
endmodule

// File: rtl/player_motion_ctrl.sv
// Per-frame player motion: horizontal walking with screen clamps, jump/gravity FSM.
module player_motion_ctrl #(
    parameter int X_START  = 0,
    parameter int Y_GROUND = vga_pkg::Y_GROUND,
    parameter int PLAYER_W = vga_pkg::PLAYER_W,
    parameter int PLAYER_H = vga_pkg::PLAYER_H,
    parameter int STEP     = 4,
    parameter int JUMP_V0  = 16,
    parameter int GRAVITY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           vga_in,
    input  logic        left,
    input  logic        right,
    input  logic        jump,
    output logic [10:0] xpos,
    output logic [10:0] ypos,
    output logic        facing_left,
    output logic        moving,
    output logic        airborne,
    output logic        frame_tick
);
    import vga_pkg::*;

    localparam int X_MAX = HOR_PIXELS - PLAYER_W;
    localparam int Y_TOP = Y_GROUND - PLAYER_H;
    localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);
    localparam logic signed [11:0] Y_TOP_S = 12'(Y_TOP);
    localparam logic signed [7:0]  V0_S    = 8'(JUMP_V0);
    localparam logic signed [7:0]  G_S     = 8'(GRAVITY);

    player_state_t      state, state_nxt;
    logic signed [7:0]  vy, vy_nxt;
    logic               jump_armed, armed_nxt;
    logic [10:0]        x_nxt, y_nxt;
    logic               facing_nxt, moving_nxt;
    logic signed [11:0] x_s, x_step, y_sum;

    frame_tick_gen u_frame_tick_gen (
        .clk        (clk),
        .rst        (rst),
        .vblnk      (vga_in.vblnk),
        .frame_tick (frame_tick)
    );

    always_comb begin
        x_s        = $signed({1'b0, xpos});
        x_step     = x_s;
        x_nxt      = xpos;
        facing_nxt = facing_left;
        if (right & ~left) begin
            x_step     = x_s + 12'(STEP);
            x_nxt      = (x_step > X_MAX_S) ? 11'(X_MAX) : x_step[10:0];
            facing_nxt = 1'b0;
        end else if (left & ~right) begin
            x_step     = x_s - 12'(STEP);
            x_nxt      = (x_step < 12'sd0) ? '0 : x_step[10:0];
            facing_nxt = 1'b1;
        end
        moving_nxt = (x_nxt != xpos);

        y_sum     = $signed({1'b0, ypos}) + $signed({{4{vy[7]}}, vy});
        state_nxt = state;
        vy_nxt    = vy;
        y_nxt     = ypos;
        armed_nxt = jump_armed | ~jump;
        case (state)
            STAND, WALK: begin
                if (jump & jump_armed) begin
                    state_nxt = JUMP;
                    vy_nxt    = -V0_S;
                    armed_nxt = 1'b0;
                end else begin
                    state_nxt = moving_nxt ? WALK : STAND;
                end
            end
            JUMP: begin
                if (y_sum >= Y_TOP_S) begin
                    y_nxt     = 11'(Y_TOP);
                    vy_nxt    = '0;
                    state_nxt = moving_nxt ? WALK : STAND;
                end else begin
                    y_nxt  = (y_sum < 12'sd0) ? '0 : y_sum[10:0];
                    // saturate before adding so vy never overflows past JUMP_V0
                    vy_nxt = (vy > V0_S - G_S) ? V0_S : vy + G_S;
                end
            end
            default: state_nxt = STAND;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= STAND;
            vy          <= '0;
            jump_armed  <= 1'b1;
            xpos        <= 11'(X_START);
            ypos        <= 11'(Y_TOP);
            facing_left <= 1'b0;
            moving      <= 1'b0;
            airborne    <= 1'b0;
        end else if (frame_tick) begin
            state       <= state_nxt;
            vy          <= vy_nxt;
            jump_armed  <= armed_nxt;
            xpos        <= x_nxt;
            ypos        <= y_nxt;
            facing_left <= facing_nxt;
            moving      <= moving_nxt;
            airborne    <= (state_nxt == JUMP);
        end
    end
endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench for player_motion_ctrl: stimulus pushes expected per-frame results, monitor checks them.
module tb_player_motion_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        left, right, jump;
    logic [10:0] xpos, ypos;
    logic        facing_left, moving, airborne, frame_tick;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int x;
        int y;
        bit f;
        bit m;
        bit a;
    } exp_t;
    exp_t q[$];

    // reference model: jump height as closed-form function of airborne tick count
    int mx, my, mk;
    bit mair, marm, mf, mm;

    vga_if vga ();

    player_motion_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .vga_in      (vga),
        .left        (left),
        .right       (right),
        .jump        (jump),
        .xpos        (xpos),
        .ypos        (ypos),
        .facing_left (facing_left),
        .moving      (moving),
        .airborne    (airborne),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int traj(input int k);
        int j;
        if (k >= 33) return 420;
        if (k <= 16) return 420 - (16 * k - (k * (k - 1)) / 2);
        j = k - 16;
        return 284 + (j * (j - 1)) / 2;
    endfunction

    task automatic model_reset();
        mx = 0; my = 420; mk = 0;
        mair = 0; marm = 1; mf = 0; mm = 0;
    endtask

    task automatic model_tick(input bit l, input bit r, input bit j);
        int nx;
        exp_t e;
        nx = mx;
        if (r && !l) begin
            nx = (mx + 4 > 994) ? 994 : mx + 4;
            mf = 0;
        end else if (l && !r) begin
            nx = (mx - 4 < 0) ? 0 : mx - 4;
            mf = 1;
        end
        mm = (nx != mx);
        mx = nx;
        if (!mair) begin
            if (j && marm) begin
                mair = 1; mk = 0; marm = 0;
            end else if (!j) begin
                marm = 1;
            end
        end else begin
            mk++;
            my = traj(mk);
            if (mk >= 33) mair = 0;
            if (!j) marm = 1;
        end
        e.x = mx; e.y = my; e.f = mf; e.m = mm; e.a = mair;
        q.push_back(e);
    endtask

    // one frame: noisy inputs, then the tick values held across the vblnk rising edge
    task automatic frame(input bit l, input bit r, input bit j);
        repeat (4) begin
            @(posedge clk); #1;
            vga.vblnk = 1'b0;
            left  = 1'($urandom_range(0, 1));
            right = 1'($urandom_range(0, 1));
            jump  = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        left = l; right = r; jump = j;
        model_tick(l, r, j);
        @(posedge clk); #1;
        vga.vblnk = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("tick_per_frame", q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_xpos"}, int'(xpos), 0);
        check({tag, "_ypos"}, int'(ypos), 420);
        check({tag, "_facing"}, int'(facing_left), 0);
        check({tag, "_moving"}, int'(moving), 0);
        check({tag, "_airborne"}, int'(airborne), 0);
        check({tag, "_tick"}, int'(frame_tick), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_tick === 1'b1 && rst === 1'b0) begin
                @(negedge clk);
                check("tick_width", int'(frame_tick), 0);
                if (q.size() == 0) begin
                    check("unexpected_tick", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("xpos", int'(xpos), e.x);
                    check("ypos", int'(ypos), e.y);
                    check("facing_left", int'(facing_left), int'(e.f));
                    check("moving", int'(moving), int'(e.m));
                    check("airborne", int'(airborne), int'(e.a));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int guard;
        vga.vcount = '0; vga.vsync = 1'b0; vga.hcount = '0;
        vga.hsync = 1'b0; vga.hblnk = 1'b0; vga.rgb = '0;
        vga.vblnk = 1'b0;
        left = 1'b0; right = 1'b0; jump = 1'b0;
        rst = 1'b1;
        model_reset();
        #13;
        check_reset_outputs("rst");
        @(negedge clk); #2;
        rst = 1'b0;

        repeat (3) frame(0, 0, 0);
        repeat (2) frame(1, 0, 0);
        repeat (10) frame(0, 1, 0);
        frame(0, 0, 0);
        frame(1, 1, 0);

        frame(0, 0, 1);
        repeat (40) frame(0, 0, 0);
        repeat (40) frame(0, 0, 1);
        frame(0, 0, 0);
        frame(0, 0, 1);
        repeat (40) frame(0, 0, 0);

        guard = 0;
        while (mx < 994 && guard < 400) begin
            frame(0, 1, 0);
            guard++;
        end
        check("reach_right_edge", int'(xpos), 994);
        repeat (35) frame(0, 1, 1);
        frame(0, 0, 0);

        repeat (300) begin
            frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 5) == 0));
        end
        repeat (40) frame(0, 0, 0);

        frame(0, 0, 1);
        repeat (10) frame(0, 0, 0);
        check("midjump_airborne", int'(airborne), 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        #3;
        rst = 1'b0;
        vga.vblnk = 1'b0;
        frame(0, 0, 0);
        frame(0, 0, 0);

        repeat (5) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
